ram_sp_clr: RTL

- Parametrised single-port synchronous RAM with registered read data, a read-valid strobe and an error strobe.
- Contains a clear engine that zeroes every word, one word per cycle, automatically after reset and again on request.
- Used as scratch and register-file storage in the datapath.
- Wherever the command rules below allow an operation, it behaves as the existing 8x32 byte memory: read and write are mutually exclusive, and read data is held between reads.

---
 rtl/ram_sp_clr.sv | 67 ++++++
 1 files changed

// File: rtl/ram_sp_clr.sv
// ram_sp_clr: single-port synchronous RAM with registered read and a one-word-per-cycle clear sweep
module ram_sp_clr #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read,
    input  logic              write,
    input  logic              clr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              busy,
    output logic              err
);
    typedef enum logic {CLEAR, IDLE} state_t;
    state_t            state_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic [DATA_W-1:0] data_out_q;
    logic              rd_valid_q, err_q, busy_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              last, oor;
    assign last     = 32'(clr_cnt_q) == DEPTH - 1;
    assign oor      = 32'(addr) >= DEPTH;
    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign err      = err_q;
    // The array is only zeroed by the sweep; reset just restarts it from word 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR;
            clr_cnt_q  <= '0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            if (state_q == CLEAR) begin
                mem[clr_cnt_q] <= '0;
                if (last) begin
                    state_q   <= IDLE;
                    clr_cnt_q <= '0;
                    busy_q    <= 1'b0;
                end else begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                end
            end else if (clr) begin
                state_q   <= CLEAR;
                clr_cnt_q <= '0;
                busy_q    <= 1'b1;
            end else if ((read && write) || ((read || write) && oor)) begin
                err_q <= 1'b1;
            end else if (write) begin
                mem[addr] <= data_in;
            end else if (read) begin
                data_out_q <= mem[addr];
                rd_valid_q <= 1'b1;
            end
        end
    end
endmodule
